itype_detector_alt_core: RTL and testbench

ITYPE_DETECTOR_ALT_CORE -- requirements
Module: itype_detector_alt

---
 rtl/connector_pkg.sv | 31 +++
 rtl/itype_detector_alt_core_if.sv | 26 ++
 rtl/itype_detector_alt_core.sv | 48 ++++
 tb/tb_itype_detector_alt_core.sv | 132 +++++++++++++
 4 files changed

// File: rtl/connector_pkg.sv
// Shared control-flow and instruction-type encodings for the commit-side
// trace connector.
package connector_pkg;

   localparam int unsigned ITYPE_LEN = 3;

   typedef enum logic [ITYPE_LEN-1:0] {
      NoCF   = 3'd0,
      Branch = 3'd1,
      Jump   = 3'd2,
      JumpR  = 3'd3,
      Return = 3'd4
   } cf_t;

   // Code 7 is reserved and never produced.
   typedef enum logic [ITYPE_LEN-1:0] {
      STD      = 3'd0,
      EXC      = 3'd1,
      INT      = 3'd2,
      ERET     = 3'd3,
      NONTAKEN = 3'd4,
      TAKEN    = 3'd5,
      UNINF    = 3'd6
   } itype_e;

   // JumpR and Return targets cannot be inferred from the static program image.
   function automatic logic is_uninferable(cf_t cf);
      return (cf == JumpR) || (cf == Return);
   endfunction

endpackage

// File: rtl/itype_detector_alt_core_if.sv
// Bundle of the commit-side signals feeding the instruction-type detector.
interface itype_detector_alt_core_if;
   import connector_pkg::*;

   logic   commit_instr_valid;
   logic   commit_ex_valid;
   logic   interrupt;
   logic   eret;
   cf_t    resolved_branch_type;
   logic   resolved_branch_taken;
   itype_e itype;
   itype_e itype_q;

   modport master (
      output commit_instr_valid, commit_ex_valid, interrupt, eret,
             resolved_branch_type, resolved_branch_taken,
      input  itype, itype_q
   );

   modport slave (
      input  commit_instr_valid, commit_ex_valid, interrupt, eret,
             resolved_branch_type, resolved_branch_taken,
      output itype, itype_q
   );

endinterface

// File: rtl/itype_detector_alt_core.sv
// Classifies each retiring slot into an itype code (priority encoded) and
// provides a registered copy of that code.
module itype_detector_alt_core
   import connector_pkg::*;
(
   input  logic   clk_i,
   input  logic   rst_ni,
   input  logic   commit_instr_valid_i,
   input  logic   commit_ex_valid_i,
   input  logic   interrupt_i,
   input  logic   eret_i,
   input  cf_t    resolved_branch_type_i,
   input  logic   resolved_branch_taken_i,
   output itype_e itype_o,
   output itype_e itype_q_o
);

   itype_e itype_d;
   itype_e itype_q;

   // Traps win over anything retiring in the same slot; unused cf codes fall to STD.
   always_comb begin
      itype_d = STD;
      if (commit_ex_valid_i) begin
         itype_d = interrupt_i ? INT : EXC;
      end else if (commit_instr_valid_i) begin
         if (eret_i) begin
            itype_d = ERET;
         end else if (resolved_branch_type_i == Branch) begin
            itype_d = resolved_branch_taken_i ? TAKEN : NONTAKEN;
         end else if (is_uninferable(resolved_branch_type_i)) begin
            itype_d = UNINF;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         itype_q <= STD;
      end else begin
         itype_q <= itype_d;
      end
   end

   assign itype_o   = itype_d;
   assign itype_q_o = itype_q;

endmodule

// File: tb/tb_itype_detector_alt_core.sv
// Directed checks of the itype priority encoder and its registered copy.
module tb_itype_detector_alt_core;
   import connector_pkg::*;

   logic clk_i;
   logic rst_ni;
   int   n_cmp;
   int   n_bad;

   itype_detector_alt_core_if bus ();

   itype_detector_alt_core dut (
      .clk_i                  (clk_i),
      .rst_ni                 (rst_ni),
      .commit_instr_valid_i   (bus.commit_instr_valid),
      .commit_ex_valid_i      (bus.commit_ex_valid),
      .interrupt_i            (bus.interrupt),
      .eret_i                 (bus.eret),
      .resolved_branch_type_i (bus.resolved_branch_type),
      .resolved_branch_taken_i(bus.resolved_branch_taken),
      .itype_o                (bus.itype),
      .itype_q_o              (bus.itype_q)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic ev, input logic irq, input logic er,
                        input logic [2:0] cf, input logic tk);
      bus.commit_instr_valid    = iv;
      bus.commit_ex_valid       = ev;
      bus.interrupt             = irq;
      bus.eret                  = er;
      bus.resolved_branch_type  = cf_t'(cf);
      bus.resolved_branch_taken = tk;
      #1;
   endtask

   initial begin
      n_cmp  = 0;
      n_bad  = 0;
      rst_ni = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
      chk("reset_q", bus.itype_q, 3'd0);

      // Combinational path is live during reset.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1);
      chk("comb_in_reset", bus.itype, 3'd5);
      @(posedge clk_i); #1;
      chk("q_held_in_reset", bus.itype_q, 3'd0);

      @(negedge clk_i);
      rst_ni = 1'b1;

      drive(1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 1'b1);
      chk("int_all", bus.itype, 3'd2);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0);
      chk("exc_ret", bus.itype, 3'd1);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1);
      chk("eret_br", bus.itype, 3'd3);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0);
      chk("br_nt", bus.itype, 3'd4);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1);
      chk("br_t", bus.itype, 3'd5);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1);
      chk("br_noval", bus.itype, 3'd0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0);
      chk("jumpr", bus.itype, 3'd6);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1);
      chk("return_tk", bus.itype, 3'd6);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1);
      chk("jump", bus.itype, 3'd0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
      chk("nocf_tk", bus.itype, 3'd0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 1'b1);
      chk("cf_unused5", bus.itype, 3'd0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0);
      chk("cf_unused7", bus.itype, 3'd0);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1);
      chk("irq_no_ex", bus.itype, 3'd0);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0);
      chk("irq_no_ex_jr", bus.itype, 3'd6);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
      chk("eret_noval", bus.itype, 3'd0);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 1'b1);
      chk("exc_over_eret", bus.itype, 3'd1);

      // Registered copy: 1-cycle latency, follows every cycle.
      @(negedge clk_i);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1);
      @(posedge clk_i); #1;
      chk("q_taken", bus.itype_q, 3'd5);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0);
      chk("q_before_edge", bus.itype_q, 3'd5);
      @(posedge clk_i); #1;
      chk("q_uninf", bus.itype_q, 3'd6);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
      @(posedge clk_i); #1;
      chk("q_int", bus.itype_q, 3'd2);

      // Mid-cycle async reset clears immediately.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1);
      @(posedge clk_i); #1;
      chk("q_taken2", bus.itype_q, 3'd5);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("q_async_clr", bus.itype_q, 3'd0);
      chk("comb_after_rst", bus.itype, 3'd5);

      // Release, then first edge captures again.
      @(negedge clk_i);
      rst_ni = 1'b1;
      #1;
      chk("q_after_release", bus.itype_q, 3'd0);
      @(posedge clk_i); #1;
      chk("q_recapture", bus.itype_q, 3'd5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
